// File: rtl/psram_arbiter.sv
// Round-robin two-port arbiter in front of the PSRAM controller.
// Issues one single-cycle strobe per transaction and returns a done pulse to the granted port.
module psram_arbiter #(
    parameter int unsigned ADDR_W = 24,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_done,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_done,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read_strb,
    output logic              mem_write_strb,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t            state, state_d;
    logic              gnt_id, gnt_id_d;
    logic              gnt_we, gnt_we_d;
    logic              last_grant, last_grant_d;
    logic [ADDR_W-1:0] mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_d;
    logic              mem_read_strb_d, mem_write_strb_d;
    logic              p0_done_d, p1_done_d;
    logic [DATA_W-1:0] p0_rdata_d, p1_rdata_d;
    logic              elig0, elig1, pick;

    // A port still showing its done pulse is masked so a held req is not re-granted at once.
    assign elig0 = p0_req & ~p0_done;
    assign elig1 = p1_req & ~p1_done;
    assign pick  = (elig0 & elig1) ? ~last_grant : elig1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            gnt_id         <= 1'b0;
            gnt_we         <= 1'b0;
            last_grant     <= 1'b1;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            mem_read_strb  <= 1'b0;
            mem_write_strb <= 1'b0;
            p0_done        <= 1'b0;
            p1_done        <= 1'b0;
            p0_rdata       <= '0;
            p1_rdata       <= '0;
        end else begin
            state          <= state_d;
            gnt_id         <= gnt_id_d;
            gnt_we         <= gnt_we_d;
            last_grant     <= last_grant_d;
            mem_addr       <= mem_addr_d;
            mem_wdata      <= mem_wdata_d;
            mem_read_strb  <= mem_read_strb_d;
            mem_write_strb <= mem_write_strb_d;
            p0_done        <= p0_done_d;
            p1_done        <= p1_done_d;
            p0_rdata       <= p0_rdata_d;
            p1_rdata       <= p1_rdata_d;
        end
    end

    always_comb begin
        state_d          = state;
        gnt_id_d         = gnt_id;
        gnt_we_d         = gnt_we;
        last_grant_d     = last_grant;
        mem_addr_d       = mem_addr;
        mem_wdata_d      = mem_wdata;
        mem_read_strb_d  = 1'b0;
        mem_write_strb_d = 1'b0;
        p0_done_d        = 1'b0;
        p1_done_d        = 1'b0;
        p0_rdata_d       = p0_rdata;
        p1_rdata_d       = p1_rdata;

        case (state)
            IDLE: begin
                if (mem_ready && (elig0 || elig1)) begin
                    gnt_id_d         = pick;
                    gnt_we_d         = pick ? p1_we : p0_we;
                    mem_addr_d       = pick ? p1_addr : p0_addr;
                    mem_wdata_d      = pick ? p1_wdata : p0_wdata;
                    last_grant_d     = pick;
                    mem_read_strb_d  = ~gnt_we_d;
                    mem_write_strb_d = gnt_we_d;
                    state_d          = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (!mem_ready) begin
                    state_d = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (mem_ready) begin
                    if (!gnt_we) begin
                        if (gnt_id) begin
                            p1_rdata_d = mem_rdata;
                        end else begin
                            p0_rdata_d = mem_rdata;
                        end
                    end
                    p0_done_d = ~gnt_id;
                    p1_done_d = gnt_id;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
